// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a dual-port RAM: independent round-robin per RAM port,
// registered RAM commands, tagged read return. Define RAM_ARB_RAW_BYPASS_EN for same-address write-to-read bypass.
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_wr_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_read,
   output logic [ADDR_WIDTH-1:0] ram_rd_address,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   localparam int DEPTH = RD_LATENCY + 1;

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

   pri_e wrPri_q, wrPri_d, rdPri_q, rdPri_d;
   logic aWrElig, bWrElig, aRdElig, bRdElig;
   logic aWrGnt, bWrGnt, aRdGnt, bRdGnt;

   logic                  ramWrite_q, ramWrite_d;
   logic [ADDR_WIDTH-1:0] ramWrAddr_q, ramWrAddr_d;
   logic [DATA_WIDTH-1:0] ramDataIn_q, ramDataIn_d;
   logic                  ramRead_q, ramRead_d;
   logic [ADDR_WIDTH-1:0] ramRdAddr_q, ramRdAddr_d;

   logic [DEPTH-1:0]      vld_q, vld_d, tag_q, tag_d;
   logic [DATA_WIDTH-1:0] retData;

   assign aWrElig = a_req & a_we;
   assign bWrElig = b_req & b_we;
   assign aRdElig = a_req & ~a_we;
   assign bRdElig = b_req & ~b_we;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wrPri_q <= PRI_A;
         rdPri_q <= PRI_A;
      end else begin
         wrPri_q <= wrPri_d;
         rdPri_q <= rdPri_d;
      end
   end

   // The pointer only moves when both requesters contend for the same port.
   always_comb begin
      wrPri_d = wrPri_q;
      rdPri_d = rdPri_q;
      if (aWrElig && bWrElig) wrPri_d = (wrPri_q == PRI_A) ? PRI_B : PRI_A;
      if (aRdElig && bRdElig) rdPri_d = (rdPri_q == PRI_A) ? PRI_B : PRI_A;
   end

   always_comb begin
      aWrGnt = 1'b0;
      bWrGnt = 1'b0;
      aRdGnt = 1'b0;
      bRdGnt = 1'b0;
      if (resetn) begin
         aWrGnt = aWrElig & (~bWrElig | (wrPri_q == PRI_A));
         bWrGnt = bWrElig & (~aWrElig | (wrPri_q == PRI_B));
         aRdGnt = aRdElig & (~bRdElig | (rdPri_q == PRI_A));
         bRdGnt = bRdElig & (~aRdElig | (rdPri_q == PRI_B));
      end
   end

   assign a_gnt = aWrGnt | aRdGnt;
   assign b_gnt = bWrGnt | bRdGnt;

   // Addresses and data hold their last value when a port is idle.
   always_comb begin
      ramWrite_d  = aWrGnt | bWrGnt;
      ramWrAddr_d = ramWrAddr_q;
      ramDataIn_d = ramDataIn_q;
      ramRead_d   = aRdGnt | bRdGnt;
      ramRdAddr_d = ramRdAddr_q;
      if (aWrGnt) begin
         ramWrAddr_d = a_addr;
         ramDataIn_d = a_wdata;
      end else if (bWrGnt) begin
         ramWrAddr_d = b_addr;
         ramDataIn_d = b_wdata;
      end
      if (aRdGnt)      ramRdAddr_d = a_addr;
      else if (bRdGnt) ramRdAddr_d = b_addr;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ramWrite_q  <= 1'b0;
         ramWrAddr_q <= '0;
         ramDataIn_q <= '0;
         ramRead_q   <= 1'b0;
         ramRdAddr_q <= '0;
      end else begin
         ramWrite_q  <= ramWrite_d;
         ramWrAddr_q <= ramWrAddr_d;
         ramDataIn_q <= ramDataIn_d;
         ramRead_q   <= ramRead_d;
         ramRdAddr_q <= ramRdAddr_d;
      end
   end

   assign ram_write      = ramWrite_q;
   assign ram_wr_address = ramWrAddr_q;
   assign ram_data_in    = ramDataIn_q;
   assign ram_read       = ramRead_q;
   assign ram_rd_address = ramRdAddr_q;

   // Stage 0 mirrors ram_read; the last stage lines up with valid ram_data_out. Tag 1 means B.
   always_comb begin
      vld_d = {vld_q[DEPTH-2:0], ramRead_d};
      tag_d = {tag_q[DEPTH-2:0], bRdGnt};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

`ifdef RAM_ARB_RAW_BYPASS_EN
   logic                                   collide;
   logic [RD_LATENCY:1]                    hit_q, hit_d;
   logic [RD_LATENCY:1][DATA_WIDTH-1:0]    byp_q, byp_d;

   assign collide = ramRead_q & ramWrite_q & (ramRdAddr_q == ramWrAddr_q);

   // Write data rides alongside the read tag so the collision result is the new value.
   always_comb begin
      hit_d    = hit_q;
      byp_d    = byp_q;
      hit_d[1] = collide;
      byp_d[1] = ramDataIn_q;
      for (int k = 2; k <= RD_LATENCY; k++) begin
         hit_d[k] = hit_q[k-1];
         byp_d[k] = byp_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_q <= '0;
         byp_q <= '0;
      end else begin
         hit_q <= hit_d;
         byp_q <= byp_d;
      end
   end

   assign retData = hit_q[RD_LATENCY] ? byp_q[RD_LATENCY] : ram_data_out;
`else
   assign retData = ram_data_out;
`endif

   assign a_rvalid = vld_q[DEPTH-1] & ~tag_q[DEPTH-1];
   assign b_rvalid = vld_q[DEPTH-1] & tag_q[DEPTH-1];
   assign a_rdata  = a_rvalid ? retData : '0;
   assign b_rdata  = b_rvalid ? retData : '0;

endmodule
